// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared MAC stepped over TAP_COUNT taps per sample,
// with a sample delay line, a programmable coefficient bank and valid/ready on both sides.
module fir_mac_sequencer #(
    parameter int unsigned TAP_COUNT   = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned ACC_WIDTH   = 18,
    parameter int unsigned OUT_SHIFT   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         coef_we,
    input  logic [$clog2(TAP_COUNT)-1:0] coef_addr,
    input  logic [COEFF_WIDTH-1:0]       coef_wdata,
    output logic                         busy
);

    localparam int unsigned AddrWidth = $clog2(TAP_COUNT);
    localparam int unsigned ProdWidth = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(TAP_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  x_q    [TAP_COUNT];
    logic [DATA_WIDTH-1:0]  x_d    [TAP_COUNT];
    logic [COEFF_WIDTH-1:0] coef_q [TAP_COUNT];
    logic [COEFF_WIDTH-1:0] coef_d [TAP_COUNT];
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [AddrWidth-1:0]   k_q, k_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic                   idle;
    logic                   accept;
    logic [ProdWidth-1:0]   prod;
    logic [ACC_WIDTH-1:0]   mac_sum;

    assign idle    = (state_q == StIdle);
    assign accept  = idle && in_valid;
    assign prod    = ProdWidth'(x_q[k_q]) * ProdWidth'(coef_q[k_q]);
    assign mac_sum = acc_q + ACC_WIDTH'(prod);

    // Gated with rst so upstream never sees a ready while the block is held in reset.
    assign in_ready  = idle && rst;
    assign busy      = !idle;
    assign out_valid = (state_q == StOut);
    assign out_data  = out_data_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        x_d        = x_q;
        coef_d     = coef_q;

        // Writes only land in IDLE so a MAC pass always sees one consistent bank.
        if (idle && coef_we) begin
            for (int i = 0; i < TAP_COUNT; i++) begin
                if (coef_addr == AddrWidth'(i)) begin
                    coef_d[i] = coef_wdata;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d[0] = in_data;
                    for (int i = 1; i < TAP_COUNT; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = mac_sum;
                k_d   = k_q + 1'b1;
                if (k_q == LastTap) begin
                    out_data_d = mac_sum[OUT_SHIFT +: DATA_WIDTH];
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            for (int i = 0; i < TAP_COUNT; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            x_q        <= x_d;
            coef_q     <= coef_d;
        end
    end

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed scenarios plus randomized traffic,
// compared against a convolution model over the history of accepted samples.
module tb_fir_mac_sequencer;

    localparam int unsigned TAPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_wdata;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: most recent accepted sample at index 0, bank of coefficients.
    int unsigned hist[$];
    int unsigned coef_m[TAPS];
    logic [7:0]  exp_out;

    fir_mac_sequencer #(
        .TAP_COUNT  (4),
        .DATA_WIDTH (8),
        .COEFF_WIDTH(8),
        .ACC_WIDTH  (18),
        .OUT_SHIFT  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        int unsigned sum = 0;
        for (int i = 0; i < TAPS; i++) begin
            if (i < hist.size()) sum += hist[i] * coef_m[i];
        end
        return 8'(sum >> 8);
    endfunction

    task automatic model_push(input logic [7:0] v);
        hist.push_front(int'(v));
        if (hist.size() > TAPS) void'(hist.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int unsigned addr, input logic [7:0] val);
        coef_we    = 1'b1;
        coef_addr  = 2'(addr);
        coef_wdata = val;
        step();
        coef_we = 1'b0;
        coef_m[addr] = int'(val);
    endtask

    task automatic program4(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
    endtask

    task automatic accept_sample(input logic [7:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        model_push(v);
        exp_out = model_out();
    endtask

    // Waits for the result, holds backpressure for 'hold' cycles, then completes the handshake.
    task automatic wait_output(input int hold, input int start, input string tag);
        int lat = start;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(TAPS));
        check({tag, "_data"}, 32'(out_data), 32'(exp_out));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp_out));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_data_kept"}, 32'(out_data), 32'(exp_out));
    endtask

    logic [7:0] imp_exp[4];
    logic [7:0] nd;

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Impulse response
        imp_exp = '{8'd16, 8'd12, 8'd46, 8'd47};
        program4(8'd17, 8'd13, 8'd47, 8'd48);
        for (int i = 0; i < 4; i++) begin
            accept_sample(i == 0 ? 8'd255 : 8'd0);
            check("impulse_model", 32'(exp_out), 32'(imp_exp[i]));
            wait_output(0, 0, "impulse");
        end

        // Full-scale truncation
        program4(8'd255, 8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 4; i++) begin
            accept_sample(8'd255);
            wait_output(0, 0, "fullscale");
        end
        check("fullscale_last", 32'(out_data), 32'd248);

        // Backpressure with upstream pushing new data all the way through
        accept_sample(8'd10);
        nd = 8'd77;
        in_valid = 1'b1;
        in_data  = nd;
        wait_output(6, 0, "bp");
        check("bp_ready_after", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        model_push(nd);
        exp_out = model_out();
        check("bp_accepted", 32'(busy), 32'd1);
        wait_output(0, 0, "bp_next");

        // Coefficient write during MAC is dropped; a later IDLE write lands
        program4(8'd17, 8'd13, 8'd47, 8'd48);
        for (int i = 0; i < 4; i++) begin
            accept_sample(8'd0);
            wait_output(0, 0, "flush");
        end
        accept_sample(8'd255);
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd0;
        step();
        coef_we = 1'b0;
        wait_output(0, 1, "macwr");
        check("macwr_first", 32'(out_data), 32'd16);
        write_coef(1, 8'd0);
        accept_sample(8'd0);
        wait_output(0, 0, "idlewr");
        check("idlewr_effect", 32'(out_data), 32'd0);

        // Same-edge coefficient write and sample accept
        program4(8'd0, 8'd0, 8'd0, 8'd0);
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd100;
        coef_m[0]  = 100;
        accept_sample(8'd128);
        coef_we = 1'b0;
        check("sameedge_model", 32'(exp_out), 32'd50);
        wait_output(0, 0, "sameedge");

        // Asynchronous reset in the middle of MAC
        accept_sample(8'd200);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        accept_sample(8'($urandom_range(1, 255)));
        wait_output(0, 0, "midrst_first");
        check("midrst_zero_out", 32'(out_data), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int hold;
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                write_coef($urandom_range(0, TAPS - 1), 8'($urandom));
            end
            accept_sample(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                coef_we    = 1'b1;
                coef_addr  = 2'($urandom);
                coef_wdata = 8'($urandom);
                step();
                coef_we = 1'b0;
                wait_output(hold, 1, "rand");
            end else begin
                wait_output(hold, 0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
